// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// next-PC source codes and the fetch timeout counter width.
package ifu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ifu_state_e;

    localparam logic [1:0] PCSEL_IN     = 2'd0;
    localparam logic [1:0] PCSEL_JUMP   = 2'd1;
    localparam logic [1:0] PCSEL_BRANCH = 2'd2;
    localparam logic [1:0] PCSEL_RST    = 2'd3;

    // Wide enough for the largest supported timeout (255 cycles).
    localparam int TIMER_W = 8;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational redirect-target computation shared by the immediate and the
// deferred redirect paths of instr_fetch_unit.
module ifu_next_pc
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic [1:0]        i_sel,
    input  logic [ADDR_W-1:0] i_pc_in,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [25:0]       i_ir,
    output logic [ADDR_W-1:0] o_target
);

    // Jump keeps the PC's top nibble (zero when ADDR_W is 28); branch adds the
    // word-scaled sign-extended immediate to the already-advanced PC.
    always_comb begin
        o_target = RESET_PC;
        case (i_sel)
            PCSEL_IN:     o_target = i_pc_in;
            PCSEL_JUMP:   o_target = ADDR_W'({4'(i_pc >> 28), i_ir, 2'b00});
            PCSEL_BRANCH: o_target = i_pc + ADDR_W'({{14{i_ir[15]}}, i_ir[15:0], 2'b00});
            default:      o_target = RESET_PC;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, IR, next-PC selection and a timed request/ready
// memory port. Define IFU_ALIGN_CHECK_EN to reject misaligned redirect targets.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch,
    input  logic              redirect,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_rdy,
    input  logic [31:0]       im_rdata,
    output logic [31:0]       ir_out,
    output logic [31:0]       se_16,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err,
    output logic              align_err
);

    ifu_state_e          r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_pend_vld;
    logic [1:0]          r_pend_sel;
    logic [ADDR_W-1:0]   r_pend_in;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic                r_im_req;
    logic [ADDR_W-1:0]   r_im_addr;
    logic                r_ir_valid;
    logic                r_fetch_err;
    logic                r_align_err;

    logic [1:0]          w_sel;
    logic [ADDR_W-1:0]   w_pc_in;
    logic [ADDR_W-1:0]   w_target;
    logic [ADDR_W-1:0]   w_tgt;
    logic                w_tgt_ok;
    logic                w_pend;
    logic                w_rsp;
    logic                w_expire;

    // A redirect in the same cycle as completion counts as pending and is the
    // newest one, so it overrides anything already latched.
    assign w_pend   = redirect | r_pend_vld;
    assign w_sel    = redirect ? pc_sel : r_pend_sel;
    assign w_pc_in  = redirect ? pc_in  : r_pend_in;
    // The request cycle itself never completes, keeping fetch-to-ir_valid >= 3.
    assign w_rsp    = im_rdy && !r_im_req;
    assign w_expire = (r_timer == TIMER_W'(TIMEOUT_CYC - 1));

    ifu_next_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_next_pc (
        .i_sel    (w_sel),
        .i_pc_in  (w_pc_in),
        .i_pc     (r_pc),
        .i_ir     (r_ir[25:0]),
        .o_target (w_target)
    );

`ifdef IFU_ALIGN_CHECK_EN
    assign w_tgt_ok = (w_target[1:0] == 2'b00);
    assign w_tgt    = w_target;
`else
    assign w_tgt_ok = 1'b1;
    assign w_tgt    = w_target & ~ADDR_W'(3);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_pend_vld  <= 1'b0;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_im_req    <= 1'b0;
            r_im_addr   <= RESET_PC;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_im_req    <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_align_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (redirect) begin
                        if (w_tgt_ok) r_pc <= w_tgt;
                        else          r_align_err <= 1'b1;
                    end else if (fetch) begin
                        r_im_req  <= 1'b1;
                        r_im_addr <= r_pc;
                        r_timer   <= '0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_rsp || w_expire) begin
                        r_state    <= IDLE;
                        r_pend_vld <= 1'b0;
                        if (!w_rsp) r_fetch_err <= 1'b1;
                        if (w_pend) begin
                            if (w_tgt_ok) r_pc <= w_tgt;
                            else          r_align_err <= 1'b1;
                        end else if (w_rsp) begin
                            r_ir       <= im_rdata;
                            r_pc       <= r_pc + ADDR_W'(4);
                            r_ir_valid <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                        if (redirect) begin
                            r_pend_vld <= 1'b1;
                            r_pend_sel <= pc_sel;
                            r_pend_in  <= pc_in;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign im_req    = r_im_req;
    assign im_addr   = r_im_addr;
    assign ir_out    = r_ir;
    assign se_16     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign pc_out    = r_pc;
    assign ir_valid  = r_ir_valid;
    assign busy      = (r_state == WAIT);
    assign fetch_err = r_fetch_err;
    assign align_err = r_align_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver predicts output pulses
// from a transaction-level model, a negedge monitor pops and compares them.
module tb_instr_fetch_unit;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          TO     = 16;

    localparam int EV_REQ   = 0;
    localparam int EV_VALID = 1;
    localparam int EV_FERR  = 2;
    localparam int EV_AERR  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch;
    logic        redirect;
    logic [1:0]  pc_sel;
    logic [31:0] pc_in;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rdy;
    logic [31:0] im_rdata;
    logic [31:0] ir_out;
    logic [31:0] se_16;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;
    logic        align_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    (RST_PC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (fetch),
        .redirect  (redirect),
        .pc_sel    (pc_sel),
        .pc_in     (pc_in),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_rdy    (im_rdy),
        .im_rdata  (im_rdata),
        .ir_out    (ir_out),
        .se_16     (se_16),
        .pc_out    (pc_out),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fetch_err (fetch_err),
        .align_err (align_err)
    );

    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] ir;
    } evt_t;

    evt_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] ir);
        return {{16{ir[15]}}, ir[15:0]};
    endfunction

    function automatic logic [31:0] target(input logic [1:0] sel, input logic [31:0] inp,
                                           input logic [31:0] pc, input logic [31:0] ir);
        case (sel)
            2'd0:    return inp;
            2'd1:    return (pc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            2'd2:    return pc + (sext(ir) << 2);
            default: return RST_PC;
        endcase
    endfunction

    task automatic push(input int kind, input logic [31:0] pc, input logic [31:0] ir);
        evt_t e;
        e.kind = kind;
        e.pc   = pc;
        e.ir   = ir;
        exp_q.push_back(e);
    endtask

    // Applies a redirect to the model; returns 1 when the target is rejected.
    task automatic model_redirect(input logic [1:0] sel, input logic [31:0] inp, output bit bad);
        logic [31:0] t;
        t   = target(sel, inp, m_pc, m_ir);
        bad = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        if (t[1:0] != 2'b00) bad = 1'b1;
        else                 m_pc = t;
`else
        m_pc = {t[31:2], 2'b00};
`endif
    endtask

    task automatic take(input int kind);
        evt_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: kind %0d seen, none expected", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        case (kind)
            EV_REQ: chk("im_addr", im_addr, e.pc);
            EV_VALID: begin
                chk("ir_out", ir_out, e.ir);
                chk("pc_on_valid", pc_out, e.pc);
                chk("se_16", se_16, sext(e.ir));
            end
            EV_FERR: begin
                chk("pc_on_ferr", pc_out, e.pc);
                chk("ir_on_ferr", ir_out, e.ir);
            end
            default: chk("pc_on_aerr", pc_out, e.pc);
        endcase
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (im_req)    take(EV_REQ);
            if (ir_valid)  take(EV_VALID);
            if (fetch_err) take(EV_FERR);
            if (align_err) take(EV_AERR);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fetch = 1'b0; redirect = 1'b0; im_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_pc = RST_PC;
        m_ir = 32'h0;
        chk("rst_pc", pc_out, RST_PC);
        chk("rst_ir", ir_out, 32'h0);
        chk("rst_se16", se_16, 32'h0);
        chk("rst_flags", {27'h0, im_req, ir_valid, busy, fetch_err, align_err}, 32'h0);
    endtask

    task automatic idle_redirect(input logic [1:0] sel, input logic [31:0] inp, input bit with_fetch);
        bit bad;
        fetch = with_fetch; redirect = 1'b1; pc_sel = sel; pc_in = inp;
        model_redirect(sel, inp, bad);
        if (bad) push(EV_AERR, m_pc, m_ir);
        tick();
        fetch = 1'b0; redirect = 1'b0;
        chk("idle_redir_pc", pc_out, m_pc);
        chk("idle_busy", busy, 1'b0);
    endtask

    // lat = WAIT cycle in which im_rdy is driven (WAIT cycle 1 carries im_req);
    // lat > TO means the memory never answers. rd_cyc selects a directed
    // redirect cycle, or 0 for random redirects.
    task automatic fetch_txn(input int lat, input logic [31:0] data, input int rd_cyc,
                             input logic [1:0] rd_sel, input logic [31:0] rd_in);
        bit          pend, bad, r;
        logic [1:0]  psel;
        logic [31:0] pin;
        int          last;
        pend = 1'b0; bad = 1'b0; psel = 2'd0; pin = 32'h0;
        fetch = 1'b1;
        push(EV_REQ, m_pc, m_ir);
        tick();
        fetch = 1'b0;
        chk("busy_in_wait", busy, 1'b1);
        last = (lat <= TO) ? lat : TO;
        for (int k = 1; k <= last; k++) begin
            im_rdy   = (k == lat);
            im_rdata = (k == lat) ? data : $urandom;
            if (rd_cyc == 0) r = ($urandom_range(0, 5) == 0);
            else             r = (k == rd_cyc);
            if (r) begin
                redirect = 1'b1;
                pc_sel   = (rd_cyc == 0) ? 2'($urandom_range(0, 3)) : rd_sel;
                pc_in    = (rd_cyc == 0) ? ($urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF))
                                         : rd_in;
                pend = 1'b1; psel = pc_sel; pin = pc_in;
            end else begin
                redirect = 1'b0;
            end
            if (k == last) begin
                if (lat <= TO) begin
                    if (pend) begin
                        model_redirect(psel, pin, bad);
                        if (bad) push(EV_AERR, m_pc, m_ir);
                    end else begin
                        m_ir = data;
                        m_pc = m_pc + 32'd4;
                        push(EV_VALID, m_pc, m_ir);
                    end
                end else begin
                    if (pend) model_redirect(psel, pin, bad);
                    push(EV_FERR, m_pc, m_ir);
                    if (bad) push(EV_AERR, m_pc, m_ir);
                end
            end
            tick();
        end
        im_rdy = 1'b0; redirect = 1'b0;
        chk("pc_after_fetch", pc_out, m_pc);
        chk("idle_after_fetch", busy, 1'b0);
    endtask

    task automatic stray_rdy();
        im_rdy = 1'b1; im_rdata = $urandom;
        tick();
        im_rdy = 1'b0;
        chk("stray_pc", pc_out, m_pc);
        chk("stray_ir", ir_out, m_ir);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch = 1'b0; redirect = 1'b0; pc_sel = 2'd0; pc_in = 32'h0;
        im_rdy = 1'b0; im_rdata = 32'h0;
        do_reset();

        fetch_txn(2, 32'h2408_FFFF, -1, 2'd0, 32'h0);
        chk("tp_first_pc", pc_out, 32'h0040_0004);
        chk("tp_first_se16", se_16, 32'hFFFF_FFFF);

        fetch_txn(2, 32'h0810_0003, -1, 2'd0, 32'h0);
        idle_redirect(2'd1, 32'h0, 1'b0);
        chk("tp_jump", pc_out, 32'h0040_000C);

        idle_redirect(2'd0, 32'h0040_0004, 1'b0);
        fetch_txn(3, 32'h1000_FFFE, -1, 2'd0, 32'h0);
        idle_redirect(2'd2, 32'h0, 1'b0);
        chk("tp_branch", pc_out, 32'h0040_0000);

        fetch_txn(3, 32'hDEAD_BEEF, 1, 2'd0, 32'h0000_0100);
        chk("tp_defer_pc", pc_out, 32'h0000_0100);
        chk("tp_defer_ir", ir_out, 32'h1000_FFFE);

        fetch_txn(TO + 1, 32'h0, -1, 2'd0, 32'h0);
        chk("tp_timeout_pc", pc_out, 32'h0000_0100);
        fetch_txn(TO, 32'h1234_5678, -1, 2'd0, 32'h0);
        chk("tp_late_rsp_pc", pc_out, 32'h0000_0104);

        idle_redirect(2'd0, 32'h0000_0102, 1'b0);
        idle_redirect(2'd0, 32'h0000_0200, 1'b1);
        idle_redirect(2'd3, 32'h0, 1'b0);

        fetch = 1'b1;
        push(EV_REQ, m_pc, m_ir);
        tick();
        fetch = 1'b0;
        tick();
        tick();
        do_reset();
        stray_rdy();

        for (int i = 0; i < 160; i++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 12)       fetch_txn($urandom_range(2, TO + 4), $urandom, 0, 2'd0, 32'h0);
            else if (op < 17)  idle_redirect(2'($urandom_range(0, 3)),
                                             $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF),
                                             1'($urandom_range(0, 1)));
            else if (op < 19)  stray_rdy();
            else               do_reset();
        end

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
